// File: rtl/bcd_time_counter.sv
// -----------------------------------------------------------------------------
// bcd_time_counter
//
// 24-hour HH:MM:SS time-of-day counter held as packed BCD. Runs entirely in
// the system clock domain; the 1 Hz divider output arrives on tick_in as a
// plain data signal. tick_in is synchronized, and each rising edge advances
// the count by one second. Set mode suspends counting and lets the user bump
// minutes and hours with debounced push-button levels.
//
// Optional feature macro: TIME_ALARM_EN
//   defined   -> registered alarm comparator drives alarm_out
//   undefined -> alarm_out tied low, alarm inputs unused, no comparator
//
// Parameters:
//   SYNC_STAGES  flops in the tick_in synchronizer (2 or 3)
//
// Ports:
//   clk        system clock (the only clock)
//   rst        synchronous, active-high reset
//   tick_in    divided 1 Hz clock, rising edge = one second
//   set_mode   1 = counting suspended, manual adjust enabled
//   inc_min    level; +1 minute per 0->1 transition in set mode
//   inc_hr     level; +1 hour per 0->1 transition in set mode
//   alarm_en   alarm enable
//   alarm_hh   alarm hour, BCD
//   alarm_mm   alarm minute, BCD
//   hh, mm, ss current time, BCD
//   sec_pulse  one-cycle strobe on every seconds advance
//   day_pulse  one-cycle strobe on the 23:59:59 -> 00:00:00 wrap
//   alarm_out  registered alarm match flag
// -----------------------------------------------------------------------------
module bcd_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       alarm_out
);

  // ---------------------------------------------------------------------------
  // BCD digit-pair increment helpers. Every digit is 4-bit with explicit wrap,
  // so an illegal code can never be produced from a legal one.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // ---------------------------------------------------------------------------
  // tick_in synchronizer, edge history and arming
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  // Marks which synchronizer stages hold a real sample since reset. The reset
  // zeros in sync_q are not an observation of tick_in being low, so they must
  // not arm the edge detector.
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   sync_out;
  logic                   tick_hist;
  logic                   armed;
  logic                   tick_qual;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign tick_qual = armed & sync_out & ~tick_hist;

  // Push-button levels: one sample flop plus one history flop each, so an
  // edge present at clock E is applied at E+1.
  logic inc_min_q, inc_min_hist;
  logic inc_hr_q,  inc_hr_hist;
  logic min_rise,  hr_rise;

  assign min_rise = inc_min_q & ~inc_min_hist;
  assign hr_rise  = inc_hr_q  & ~inc_hr_hist;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // shift chain a chain rather than a single wire.
    if (rst) begin
      sync_q       <= '0;
      sync_vld     <= '0;
      tick_hist    <= 1'b0;
      armed        <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_min_hist <= 1'b0;
      inc_hr_q     <= 1'b0;
      inc_hr_hist  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], tick_in};
      sync_vld     <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      tick_hist    <= sync_out;
      // Once tick_in has genuinely been seen low, every later rise is real.
      if (sync_vld[SYNC_STAGES-1] && !sync_out) armed <= 1'b1;
      inc_min_q    <= inc_min;
      inc_min_hist <= inc_min_q;
      inc_hr_q     <= inc_hr;
      inc_hr_hist  <= inc_hr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Time next-state logic
  // ---------------------------------------------------------------------------
  logic [7:0] hh_nxt, mm_nxt, ss_nxt;
  logic       sec_nxt, day_nxt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    hh_nxt  = hh;
    mm_nxt  = mm;
    ss_nxt  = ss;
    sec_nxt = 1'b0;
    day_nxt = 1'b0;

    if (set_mode) begin
      // Set mode swallows any qualified tick, including one that lands on
      // the very cycle set_mode rises. Minutes do not carry into hours here.
      ss_nxt = 8'h00;
      if (min_rise) mm_nxt = bcd_inc60(mm);
      if (hr_rise)  hh_nxt = bcd_inc24(hh);
    end else if (tick_qual) begin
      sec_nxt = 1'b1;
      ss_nxt  = bcd_inc60(ss);
      if (ss == 8'h59) begin
        mm_nxt = bcd_inc60(mm);
        if (mm == 8'h59) begin
          hh_nxt  = bcd_inc24(hh);
          day_nxt = (hh == 8'h23);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      hh        <= hh_nxt;
      mm        <= mm_nxt;
      ss        <= ss_nxt;
      sec_pulse <= sec_nxt;
      day_pulse <= day_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm comparator
  // ---------------------------------------------------------------------------
`ifdef TIME_ALARM_EN
  // Compares the registered time, so the flag trails hh/mm by one cycle and
  // stays up for the whole matching minute.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_out <= 1'b0;
    end else begin
      alarm_out <= alarm_en && (hh == alarm_hh) && (mm == alarm_mm) && !set_mode;
    end
  end
`else
  assign alarm_out = 1'b0;

  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_en, alarm_hh, alarm_mm};
`endif

endmodule
